// File: rtl/packer_pkg.sv
// Shared definitions for the fixed-to-float packer: format constants,
// FSM state encoding and float field layout.
package packer_pkg;

  localparam int FP_BIAS  = 127;
  localparam int Q_FRAC   = 30;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ABS  = 2'd1,
    S_NORM = 2'd2,
    S_RND  = 2'd3
  } state_t;

  function automatic logic [31:0] pack_float(input logic s, input logic [7:0] e,
                                             input logic [22:0] m);
    logic [31:0] f;
    f = '0;
    f[SIGN_BIT]        = s;
    f[EXP_MSB:EXP_LSB] = e;
    f[MANT_MSB:0]      = m;
    return f;
  endfunction

endpackage

// File: rtl/packer_rne_round.sv
// Round-to-nearest-even of a normalised magnitude (hidden bit already dropped)
// into a 23-bit mantissa, bumping the exponent on mantissa carry-out.
module packer_rne_round
  import packer_pkg::*;
(
  input  logic [30:0]       mag,
  input  logic [7:0]        exp,
  output logic [7:0]        exp_out,
  output logic [MANT_MSB:0] mant_out
);

  logic        guard;
  logic        sticky;
  logic        round_up;
  logic [23:0] sum;

  assign guard    = mag[7];
  assign sticky   = |mag[6:0];
  assign round_up = guard & (sticky | mag[8]);

  // Carry-out leaves sum[22:0] at zero, which is exactly the wrapped mantissa.
  assign sum      = {1'b0, mag[30:8]} + {23'd0, round_up};
  assign mant_out = sum[MANT_MSB:0];
  assign exp_out  = exp + {7'd0, sum[23]};

endmodule

// File: rtl/packer.sv
// Q2.30 signed fixed-point to IEEE-754 single converter: abs, one-bit-per-cycle
// normalisation, then round-to-nearest-even. start/done handshake, clk_en freeze.
//
// state | meaning
// IDLE  | waiting for start; result held
// ABS   | take sign and magnitude, load initial exponent, zero short-cut
// NORM  | shift left until mag[31] set, decrementing exponent
// RND   | round, pack, pulse done
module packer
  import packer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = Q_FRAC,
  parameter int BIAS      = FP_BIAS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] dataa,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [8:0] EXP_INIT = 9'(BIAS + WIDTH - 1 - FRAC_BITS);

  state_t           state;
  logic [WIDTH-1:0] mag_q;
  logic [8:0]       exp_q;
  logic             sign_q;

  logic [WIDTH-1:0] mag_abs;
  logic [7:0]       rnd_exp;
  logic [22:0]      rnd_mant;

  // Unsigned magnitude: -0x80000000 stays 0x80000000, which is the correct |x|.
  assign mag_abs = mag_q[WIDTH-1] ? -mag_q : mag_q;

  packer_rne_round u_rnd (
    .mag      (mag_q[30:0]),
    .exp      (exp_q[7:0]),
    .exp_out  (rnd_exp),
    .mant_out (rnd_mant)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      mag_q  <= '0;
      exp_q  <= '0;
      sign_q <= 1'b0;
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mag_q <= dataa;
            busy  <= 1'b1;
            state <= S_ABS;
          end
        end
        S_ABS: begin
          sign_q <= mag_q[WIDTH-1];
          mag_q  <= mag_abs;
          exp_q  <= EXP_INIT;
          if (mag_q == '0) begin
            result <= '0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            state  <= S_NORM;
          end
        end
        S_NORM: begin
          if (!mag_q[WIDTH-1]) begin
            mag_q <= {mag_q[WIDTH-2:0], 1'b0};
            exp_q <= exp_q - 9'd1;
          end else begin
            state <= S_RND;
          end
        end
        S_RND: begin
          result <= pack_float(sign_q, rnd_exp, rnd_mant);
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packer.sv
// Scoreboard bench for packer: stimulus pushes expected result and due edge,
// a monitor pops and checks on every fresh done pulse.
module tb_packer;

  logic        clk;
  logic        reset_n;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        busy;
  logic        done;
  logic [31:0] result;

  packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (start),
    .dataa   (dataa),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [31:0] res;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_pass  = 0;
  int   n_total = 0;
  logic chk_low = 1'b0;
  logic en_edge;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Monitor: done only changes on enabled edges, so an enabled edge followed by
  // done high marks a fresh pulse.
  initial begin
    forever begin
      @(posedge clk);
      en_edge = clk_en;
      #1;
      if (en_edge && reset_n) begin
        if (chk_low) begin
          check("done_one_cycle", {31'd0, done}, 32'd0);
          chk_low = 1'b0;
        end
        if (done) begin
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_done: got result %h with nothing pending", result);
          end else begin
            cur = sb.pop_front();
            check("result", result, cur.res);
            check("latency_edge", 32'(edge_cnt), 32'(cur.due));
            check("busy_at_done", {31'd0, busy}, 32'd0);
            chk_low = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL timeout: %0d results still pending after %0d cycles", sb.size(), bound);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Done appears in cycle lat, counting the start-sampling edge as cycle 0.
  task automatic issue(input logic [31:0] d, input logic [31:0] r, input int lat);
    @(negedge clk);
    dataa = d;
    start = 1'b1;
    sb.push_back('{r, edge_cnt + lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic convert(input logic [31:0] d, input logic [31:0] r, input int lat);
    issue(d, r, lat);
    wait_idle(60);
  endtask

  initial begin
    reset_n = 1'b0;
    clk_en  = 1'b1;
    start   = 1'b0;
    dataa   = '0;
    #23;
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    convert(32'h4000_0000, 32'h3F80_0000, 5);
    convert(32'hC000_0000, 32'hBF80_0000, 5);
    convert(32'h0000_0001, 32'h3080_0000, 35);
    convert(32'h0000_0000, 32'h0000_0000, 2);
    convert(32'h8000_0000, 32'hC000_0000, 4);
    convert(32'h4000_0040, 32'h3F80_0000, 5);
    convert(32'h4000_00C0, 32'h3F80_0002, 5);
    convert(32'h7FFF_FFFF, 32'h4000_0000, 5);

    // start while busy must be dropped
    issue(32'h2000_0000, 32'h3F00_0000, 6);
    check("busy_mid_op", {31'd0, busy}, 32'd1);
    dataa = 32'h1000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(60);
    repeat (40) @(negedge clk);
    check("result_held", result, 32'h3F00_0000);
    check("busy_after", {31'd0, busy}, 32'd0);

    // clk_en low for 5 edges during NORM: lz=15 -> 19 cycles + 5
    issue(32'h0001_0000, 32'h3880_0000, 24);
    @(negedge clk);
    clk_en = 1'b0;
    repeat (5) @(negedge clk);
    clk_en = 1'b1;
    wait_idle(60);

    // asynchronous reset mid-NORM
    issue(32'h0000_0001, 32'h3080_0000, 35);
    repeat (4) @(negedge clk);
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    sb.delete();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    convert(32'h4000_0000, 32'h3F80_0000, 5);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
